// File: rtl/mem_stage_pkg.sv
// Shared encodings and types for the MEM pipeline stage.
// No logic, so no latency or backpressure of its own.
package mem_stage_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_NPC  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Load context held while a multi-cycle read is in flight.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] size;
        logic       unsigned_ld;
        logic [2:0] off;
    } ld_ctx_t;

    // Access width in bytes; dword only exists on a 64-bit datapath.
    function automatic logic [3:0] size_bytes(input logic [1:0] size, input logic wide);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return wide ? 4'd8 : 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_pipe_dmem_array.sv
// Byte-addressable data memory: byte-enable write, read through an RD_LAT-1 deep output pipe.
// Latency: write lands at the edge; read data is ready for capture on the RD_LAT-th edge after the address.
// Backpressure: none; the caller guarantees one access per accept.
module dmem_array #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [XLEN/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [XLEN-1:0]          rdata
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // The consumer's own output register is the last read stage.
    if (RD_LAT == 1) begin : g_comb
        logic unused_rst;
        assign unused_rst = rst_n;
        assign rdata      = mem[raddr];
    end else begin : g_pipe
        logic [XLEN-1:0] pipe_q [RD_LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= mem[raddr];
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign rdata = pipe_q[RD_LAT-2];
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage: sub-word load/store into local dmem, write-back select, registered MEM/WB outputs.
// Latency: 1 cycle for non-loads, RD_LAT cycles for loads; mem_stall holds EX/MEM while a load is in flight.
// Backpressure: mem_stall depends on FSM state only. Optional trap on misaligned access: MEM_MISALIGN_TRAP_EN.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_wb_sel,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_alu_out,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic [XLEN-1:0]   ex_npc,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_misalign
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept, is_store, is_load, misalign, start_busy, mem_we;
    logic [3:0]        nbytes;
    logic [OFFW-1:0]   off_raw, off_al, size_mask;
    logic [AW-1:0]     word_addr;
    logic [NB-1:0]     be_mask, mem_be;
    logic [XLEN-1:0]   mem_wdata, rd_data, sh, ld_val, nm_now, nm_q;
    logic [REG_AW-1:0] rd_q;
    ld_ctx_t           ctx_now, ctx_q, ctx_sel;

    assign mem_stall  = (state_q == BUSY);
    assign accept     = ex_valid && !mem_stall;
    assign is_store   = ex_mem_write;
    assign is_load    = ex_mem_read && !ex_mem_write;
    assign nbytes     = size_bytes(ex_size, XLEN == 64);
    assign size_mask  = OFFW'(nbytes - 4'd1);
    assign off_raw    = ex_alu_out[OFFW-1:0];
    assign off_al     = off_raw & ~size_mask;
    assign word_addr  = ex_alu_out[OFFW+AW-1:OFFW];

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misalign    = |(off_raw & size_mask);
    assign wb_misalign = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && misalign;
        end
    end
`else
    assign misalign    = 1'b0;
    assign wb_misalign = 1'b0;
`endif

    assign start_busy = accept && is_load && !misalign && (RD_LAT > 1);
    assign mem_we     = accept && is_store && !misalign;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < NB; i++) begin
            be_mask[i] = (4'(i) < nbytes);
        end
        mem_be    = be_mask << off_al;
        mem_wdata = ex_store_data << {off_al, 3'b000};
    end

    dmem_array #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (word_addr),
        .wdata (mem_wdata),
        .raddr (word_addr),
        .rdata (rd_data)
    );

    always_comb begin
        ctx_now.reg_write   = ex_reg_write;
        ctx_now.wb_sel      = ex_wb_sel;
        ctx_now.size        = ex_size;
        ctx_now.unsigned_ld = ex_unsigned;
        ctx_now.off         = 3'(off_al);
    end

    // In BUSY the extraction must follow the load that was accepted, not the live inputs.
    assign ctx_sel = (state_q == BUSY) ? ctx_q : ctx_now;
    assign sh      = rd_data >> {ctx_sel.off, 3'b000};

    always_comb begin
        ld_val = sh;
        case (ctx_sel.size)
            SZ_B: begin
                if (ctx_sel.unsigned_ld) ld_val = XLEN'(sh[7:0]);
                else                     ld_val = XLEN'($signed(sh[7:0]));
            end
            SZ_H: begin
                if (ctx_sel.unsigned_ld) ld_val = XLEN'(sh[15:0]);
                else                     ld_val = XLEN'($signed(sh[15:0]));
            end
            SZ_W: begin
                if (XLEN == 64) begin
                    if (ctx_sel.unsigned_ld) ld_val = XLEN'(sh[31:0]);
                    else                     ld_val = XLEN'($signed(sh[31:0]));
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ex_wb_sel)
            WB_ALU:  nm_now = ex_alu_out;
            WB_NPC:  nm_now = ex_npc;
            default: nm_now = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_busy) begin
                    state_d = BUSY;
                    cnt_d   = 4'(RD_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            ctx_q        <= '0;
            rd_q         <= '0;
            nm_q         <= '0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            if (state_q == BUSY) begin
                if (cnt_q == 4'd1) begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= ctx_q.reg_write;
                    wb_rd        <= rd_q;
                    wb_data      <= (ctx_q.wb_sel == WB_MEM) ? ld_val : nm_q;
                end
            end else if (ex_valid) begin
                if (start_busy) begin
                    ctx_q <= ctx_now;
                    rd_q  <= ex_rd;
                    nm_q  <= nm_now;
                end else begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= ex_reg_write && !is_store && !misalign;
                    wb_rd        <= ex_rd;
                    wb_data      <= (ex_wb_sel == WB_MEM && !misalign) ? ld_val : nm_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: one instance at RD_LAT=1, one at RD_LAT=3, shared EX/MEM inputs.
// Expectations are hand-computed; MEM_MISALIGN_TRAP_EN selects the trap or masking expectations.
module tb_mem_stage_pipe;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid1 = 1'b0, ex_valid3 = 1'b0;
    logic        ex_reg_write = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [1:0]  ex_wb_sel = 2'b00, ex_size = 2'b00;
    logic        ex_unsigned = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_alu_out = '0, ex_store_data = '0, ex_npc = '0;

    logic        mem_stall1, wb_valid1, wb_reg_write1, wb_misalign1;
    logic [4:0]  wb_rd1;
    logic [31:0] wb_data1;
    logic        mem_stall3, wb_valid3, wb_reg_write3, wb_misalign3;
    logic [4:0]  wb_rd3;
    logic [31:0] wb_data3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.XLEN(32), .DEPTH(1024), .RD_LAT(1), .REG_AW(5)) u1 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid1), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_sel(ex_wb_sel),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_npc(ex_npc), .mem_stall(mem_stall1),
        .wb_valid(wb_valid1), .wb_reg_write(wb_reg_write1), .wb_rd(wb_rd1),
        .wb_data(wb_data1), .wb_misalign(wb_misalign1)
    );

    mem_stage_pipe #(.XLEN(32), .DEPTH(1024), .RD_LAT(3), .REG_AW(5)) u3 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid3), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_sel(ex_wb_sel),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_npc(ex_npc), .mem_stall(mem_stall3),
        .wb_valid(wb_valid3), .wb_reg_write(wb_reg_write3), .wb_rd(wb_rd3),
        .wb_data(wb_data3), .wb_misalign(wb_misalign3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic r, input logic w, input logic [1:0] sel, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] d);
        ex_mem_read   = r;
        ex_mem_write  = w;
        ex_wb_sel     = sel;
        ex_size       = sz;
        ex_unsigned   = u;
        ex_alu_out    = a;
        ex_store_data = d;
    endtask

    initial begin
        int stall_cnt, edges, got, bad;

        tick;
        tick;
        chk("rst wb_valid", wb_valid1, 0);
        chk("rst wb_reg_write", wb_reg_write1, 0);
        chk("rst wb_rd", wb_rd1, 0);
        chk("rst wb_data", wb_data1, 0);
        chk("rst wb_misalign", wb_misalign1, 0);
        chk("rst stall3", mem_stall3, 0);
        rst_n = 1'b1;

        // RD_LAT=1 instance
        ex_valid1 = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
        op(0, 1, WB_ALU, SZ_W, 0, 32'h10, 32'hDEADBEEF);
        tick;
        chk("st_w valid", wb_valid1, 1);
        chk("st_w regw forced 0", wb_reg_write1, 0);
        chk("st_w stall", mem_stall1, 0);

        ex_rd = 5'd3;
        op(1, 0, WB_MEM, SZ_W, 0, 32'h10, 0);
        tick;
        chk("ld_w data", wb_data1, 32'hDEADBEEF);
        chk("ld_w valid", wb_valid1, 1);
        chk("ld_w regw", wb_reg_write1, 1);
        chk("ld_w rd", wb_rd1, 3);
        chk("ld_w stall", mem_stall1, 0);

        op(0, 1, WB_ALU, SZ_B, 0, 32'h13, 32'h80);
        tick;
        op(1, 0, WB_MEM, SZ_B, 0, 32'h13, 0);
        tick;
        chk("ld_b signed", wb_data1, 32'hFFFFFF80);
        op(1, 0, WB_MEM, SZ_B, 1, 32'h13, 0);
        tick;
        chk("ld_b unsigned", wb_data1, 32'h00000080);
        op(1, 0, WB_MEM, SZ_W, 0, 32'h10, 0);
        tick;
        chk("ld_w after st_b", wb_data1, 32'h80ADBEEF);
        op(1, 0, WB_MEM, SZ_H, 0, 32'h12, 0);
        tick;
        chk("ld_h signed", wb_data1, 32'hFFFF80AD);

        ex_valid1 = 1'b0;
        tick;
        chk("bubble valid", wb_valid1, 0);
        chk("bubble regw", wb_reg_write1, 0);

        ex_valid1 = 1'b1; ex_rd = 5'd31; ex_npc = 32'h400;
        op(0, 0, WB_NPC, SZ_W, 0, 32'h99, 0);
        tick;
        chk("npc data", wb_data1, 32'h400);
        chk("npc rd", wb_rd1, 31);
        chk("npc regw", wb_reg_write1, 1);
        chk("npc valid", wb_valid1, 1);
        op(0, 0, WB_ALU, SZ_W, 0, 32'h1234, 0);
        tick;
        chk("alu data", wb_data1, 32'h1234);
        op(0, 0, WB_ZERO, SZ_W, 0, 32'h1234, 0);
        tick;
        chk("zero data", wb_data1, 0);

        op(1, 0, WB_MEM, SZ_W, 0, 32'h1010, 0);
        tick;
        chk("alias ld_w", wb_data1, 32'h80ADBEEF);

        op(0, 1, WB_ALU, SZ_H, 0, 32'h11, 32'h5555);
        tick;
        chk("mis st_h regw", wb_reg_write1, 0);
        chk("mis st_h valid", wb_valid1, 1);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis st_h flag", wb_misalign1, 1);
`else
        chk("mis st_h flag", wb_misalign1, 0);
`endif
        op(1, 0, WB_MEM, SZ_W, 0, 32'h10, 0);
        tick;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis st_h mem", wb_data1, 32'h80ADBEEF);
        chk("mis flag clears", wb_misalign1, 0);
`else
        chk("mis st_h mem", wb_data1, 32'h80AD5555);
`endif
        op(1, 0, WB_MEM, SZ_H, 1, 32'h11, 0);
        tick;
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis ld_h flag", wb_misalign1, 1);
        chk("mis ld_h regw", wb_reg_write1, 0);
        chk("mis ld_h valid", wb_valid1, 1);
`else
        chk("mis ld_h data", wb_data1, 32'h00005555);
        chk("mis ld_h regw", wb_reg_write1, 1);
`endif

        op(1, 1, WB_MEM, SZ_B, 0, 32'h14, 32'hA5);
        tick;
        chk("rd+wr regw", wb_reg_write1, 0);
        op(1, 0, WB_MEM, SZ_B, 1, 32'h14, 0);
        tick;
        chk("rd+wr stored", wb_data1, 32'hA5);
        ex_valid1 = 1'b0;

        // RD_LAT=3 instance
        ex_valid3 = 1'b1; ex_rd = 5'd7;
        op(0, 1, WB_ALU, SZ_W, 0, 32'h20, 32'h12345678);
        tick;
        chk("l3 st valid", wb_valid3, 1);
        chk("l3 st stall", mem_stall3, 0);

        op(1, 0, WB_MEM, SZ_W, 0, 32'h20, 0);
        stall_cnt = 0; edges = 0; got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick;
            edges++;
            if (mem_stall3) stall_cnt++;
            if (wb_valid3) got = 1;
        end
        chk("l3 ld completes", got, 1);
        chk("l3 ld edges", edges, 3);
        chk("l3 stall cycles", stall_cnt, 2);
        chk("l3 ld data", wb_data3, 32'h12345678);
        chk("l3 ld rd", wb_rd3, 7);
        chk("l3 ld regw", wb_reg_write3, 1);
        ex_valid3 = 1'b0;
        tick;
        chk("l3 idle valid", wb_valid3, 0);

        ex_valid3 = 1'b1;
        tick;
        chk("l3 busy before rst", mem_stall3, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy stall", mem_stall3, 0);
        chk("rst busy valid", wb_valid3, 0);
        chk("rst busy data", wb_data3, 0);
        ex_valid3 = 1'b0;
        tick;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (wb_valid3 || mem_stall3) bad = 1;
        end
        chk("post rst no stale", bad, 0);

        ex_valid3 = 1'b1; ex_rd = 5'd9;
        op(1, 0, WB_ALU, SZ_W, 0, 32'h20, 0);
        tick;
        chk("l3 alu e0 valid", wb_valid3, 0);
        chk("l3 alu e0 stall", mem_stall3, 1);
        tick;
        chk("l3 alu e1 stall", mem_stall3, 1);
        tick;
        chk("l3 alu done valid", wb_valid3, 1);
        chk("l3 alu data", wb_data3, 32'h20);
        chk("l3 alu stall", mem_stall3, 0);
        ex_valid3 = 1'b0;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
